rc4_xor_stream: RTL and testbench
=================================

# rc4_xor_stream

Combining stage directly downstream of the RC4 keystream generator. It accepts keystream bytes over a valid/ready handshake and buffers them in a small prefetch FIFO. It optionally discards the first DROP_N bytes (RC4-drop[n]), then XORs each buffered byte with one plaintext byte to produce a ciphertext byte stream with end-of-message marking. Decryption uses the same block: feed ciphertext in on the plaintext port.

## Interface
- DROP_N, 0: keystream bytes discarded after each start; range 0..1023.
- FIFO_DEPTH, 4: keystream prefetch depth; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse beginning a message; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- ks_data  in  8  keystream byte from the generator.
- ks_valid  in  1  keystream byte available.
- ks_ready  out  1  block accepts a keystream byte.
- pt_data  in  8  plaintext byte.
- pt_valid  in  1  plaintext byte available.
- pt_last  in  1  marks the final plaintext byte of the message.
- pt_ready  out  1  plaintext byte consumed this cycle.
- ct_data  out  8  ciphertext byte (registered).
- ct_valid  out  1  ciphertext byte available.
- ct_last  out  1  final byte of the message.
- ct_ready  in  1  downstream accepts ct.
- byte_cnt  out  16  ciphertext bytes produced since start; wraps 65535→0.
- done  out  1  one-cycle pulse when the last byte has been accepted downstream.

## Operation
- States: IDLE, DISCARD, RUN, DRAIN.
- IDLE, start=1:
  - FIFO cleared, byte_cnt←0, drop counter←0.
  - Next state DISCARD if DROP_N>0, else RUN.
- DISCARD:
  - ks_ready=1; each ks handshake increments the drop counter. The FIFO is not written.
  - On the DROP_N-th handshake, go to RUN.
- RUN:
  - Push: ks_ready = (fifo_count < FIFO_DEPTH). ks_ready depends only on registered count, never on same-cycle pop.
  - A ks handshake pushes ks_data.
  - Combine condition: fifo nonempty AND pt_valid AND (ct_valid==0 OR ct_ready).
  - When the combine condition holds:
    - pt_ready=1 and the FIFO pops.
    - ct_data←pt_data^fifo_head, ct_last←pt_last, ct_valid←1, byte_cnt+1.
  - pt_ready=0 whenever the combine condition is false.
  - A combine with pt_last=1 moves to DRAIN.
  - Simultaneous push and pop: both occur; count unchanged.
- DRAIN:
  - ks_ready=0, pt_ready=0.
  - When ct_valid&ct_ready: ct_valid←0, done=1, FIFO cleared, go to IDLE.
- IDLE: ks_ready=0, pt_ready=0. Unconsumed prefetched keystream is discarded at message end, because upstream re-keys per message.
- ct_valid drop rule: ct_valid falls when ct_ready=1 and no new combine occurs in that cycle.
- start outside IDLE is ignored. pt_valid in IDLE or DISCARD is not consumed.

## Timing
- Reset values: state=IDLE, busy=0, ks_ready=0, pt_ready=0, ct_valid=0, ct_last=0, ct_data=0, byte_cnt=0, done=0, FIFO empty.
- Reset mid-message takes effect on the next edge: all outputs return to reset values and the partial message is abandoned.
- State entry latencies:
  - start → DISCARD/RUN at next edge; busy=1 from that edge.
  - DISCARD→RUN on the edge that accepts the DROP_N-th byte.
- Keystream path:
  - No FIFO bypass. A keystream byte accepted at edge N can be combined at the earliest in cycle N+1.
  - That ct_valid appears at edge N+2.
- Data path:
  - ct_valid rises 1 cycle after the combining pt handshake.
  - Sustained throughput is 1 byte/cycle with ks_valid, pt_valid and ct_ready held high.
- Backpressure:
  - With ct_ready=0, ct_data/ct_last are held stable and pt_ready=0.
  - The FIFO keeps filling up to FIFO_DEPTH.
- done asserts in the same cycle as the final ct handshake; busy=0 from the following edge.

## Structure
- Package rc4_pkg: state enum (IDLE, DISCARD, RUN, DRAIN), 8-bit byte type, default DROP_N/FIFO_DEPTH constants.
- Sub-module rc4_ks_fifo:
  - Synchronous FIFO, parameter DEPTH.
  - Ports: push, pop, clear, din, dout (head, combinational read), count, full, empty.
- Top holds the FSM, drop counter (10-bit), output register and byte_cnt.

## Test plan
- DROP_N=0, ks=0x01,0x02,0x03, pt=0x10,0x20,0x30 (last on 0x30), ct_ready=1 → ct=0x11,0x22,0x33, ct_last on the third byte, done pulse, byte_cnt=3.
- DROP_N=2, ks=0xAA,0xBB,0x5C, pt=0x5C (last) → first two ks bytes consumed without output; ct=0x00; done=1.
- Backpressure: ct_ready=0 for 10 cycles mid-stream, FIFO_DEPTH=4 → ks_ready falls after 4 pushes, ct_data stable, no byte lost or duplicated on release.
- Throughput: 16 bytes streaming, all valid/ready high → ct_valid high for 16 consecutive cycles after the initial 2-cycle latency.
- rst=1 asserted in RUN with 2 bytes in FIFO → next cycle all outputs at reset values. A fresh start then produces correct output from new ks bytes only.
- start pulsed while busy, and pt_valid held high in IDLE → ignored; pt_ready stays 0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream XOR combining stage.
// Provides the FSM state encoding, the byte type, default parameter values and
// the width of the keystream drop counter.
package rc4_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDiscard,
        StRun,
        StDrain
    } state_e;

    typedef logic [7:0] byte_t;

    localparam int unsigned DefaultDropN     = 0;
    localparam int unsigned DefaultFifoDepth = 4;

    // DROP_N is limited to 0..1023, so ten bits cover every discard count.
    localparam int unsigned DropCntW = 10;

endpackage

// File: rtl/rc4_xor_stream_if.sv
// Stream bundle for the RC4 XOR stage.
// ks_*: keystream input (valid/ready), pt_*: plaintext input (valid/ready/last),
// ct_*: ciphertext output (valid/ready/last).
// master: the surrounding system (drives keystream and plaintext, sinks ciphertext).
// slave:  the combining block itself.
interface rc4_xor_stream_if;
    import rc4_pkg::*;

    byte_t ks_data;
    logic  ks_valid;
    logic  ks_ready;

    byte_t pt_data;
    logic  pt_valid;
    logic  pt_last;
    logic  pt_ready;

    byte_t ct_data;
    logic  ct_valid;
    logic  ct_last;
    logic  ct_ready;

    modport master (
        output ks_data, ks_valid,
        input  ks_ready,
        output pt_data, pt_valid, pt_last,
        input  pt_ready,
        input  ct_data, ct_valid, ct_last,
        output ct_ready
    );

    modport slave (
        input  ks_data, ks_valid,
        output ks_ready,
        input  pt_data, pt_valid, pt_last,
        output pt_ready,
        output ct_data, ct_valid, ct_last,
        input  ct_ready
    );

endinterface

// File: rtl/rc4_ks_fifo.sv
// Keystream prefetch FIFO.
// Ports: clk/rst (sync, active-high), push/pop requests, clear (empties the FIFO,
// wins over push/pop), din (write data), dout (head byte, combinational read),
// count (occupancy 0..DEPTH), full, empty. DEPTH must be a power of two >= 2.
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultFifoDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  byte_t                  din,
    output byte_t                  dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    byte_t            mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !clear;
        do_pop   = pop && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rc4_xor_stream.sv
// RC4 keystream XOR combining stage.
// Buffers keystream bytes in a prefetch FIFO, optionally discards the first DROP_N
// keystream bytes after each start, and XORs buffered keystream with plaintext to
// produce a registered ciphertext stream with end-of-message marking.
// Ports: clk/rst (sync, active-high), start (message start pulse, IDLE only),
// busy (not IDLE), strm (keystream/plaintext/ciphertext handshakes), byte_cnt
// (ciphertext bytes since start, wrapping), done (pulse on final ct handshake).
module rc4_xor_stream
    import rc4_pkg::*;
#(
    parameter int unsigned DROP_N     = DefaultDropN,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    rc4_xor_stream_if.slave     strm,
    output logic [15:0]         byte_cnt,
    output logic                done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [DropCntW-1:0] DropLast = DropCntW'(DROP_N - 1);

    state_e              state_q, state_d;
    logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
    byte_t               ct_data_q, ct_data_d;
    logic                ct_valid_q, ct_valid_d;
    logic                ct_last_q, ct_last_d;
    logic [15:0]         byte_cnt_q, byte_cnt_d;

    logic                ks_rdy, pt_rdy, combine, done_c;
    logic                fifo_push, fifo_pop, fifo_clear;
    byte_t               fifo_head;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_full, fifo_empty;

    rc4_ks_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ks_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .din   (strm.ks_data),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        ct_data_d  = ct_data_q;
        ct_valid_d = ct_valid_q;
        ct_last_d  = ct_last_q;
        byte_cnt_d = byte_cnt_q;
        ks_rdy     = 1'b0;
        pt_rdy     = 1'b0;
        combine    = 1'b0;
        done_c     = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    fifo_clear = 1'b1;
                    byte_cnt_d = '0;
                    drop_cnt_d = '0;
                    state_d    = (DROP_N > 0) ? StDiscard : StRun;
                end
            end
            StDiscard: begin
                // Dropped keystream bypasses the FIFO entirely.
                ks_rdy = 1'b1;
                if (strm.ks_valid) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                    if (drop_cnt_q == DropLast) state_d = StRun;
                end
            end
            StRun: begin
                // Registered occupancy only: a same-cycle pop never frees a slot early.
                ks_rdy    = (fifo_count < FullCnt);
                fifo_push = strm.ks_valid && ks_rdy;
                combine   = !fifo_empty && strm.pt_valid && (!ct_valid_q || strm.ct_ready);
                if (combine) begin
                    pt_rdy     = 1'b1;
                    fifo_pop   = 1'b1;
                    ct_data_d  = strm.pt_data ^ fifo_head;
                    ct_last_d  = strm.pt_last;
                    ct_valid_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (strm.pt_last) state_d = StDrain;
                end else if (strm.ct_ready) begin
                    ct_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (ct_valid_q && strm.ct_ready) begin
                    ct_valid_d = 1'b0;
                    done_c     = 1'b1;
                    // Leftover keystream belongs to the old key; upstream re-keys per message.
                    fifo_clear = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            drop_cnt_q <= '0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            ct_last_q  <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            ct_data_q  <= ct_data_d;
            ct_valid_q <= ct_valid_d;
            ct_last_q  <= ct_last_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = done_c;
    assign byte_cnt      = byte_cnt_q;
    assign strm.ks_ready = ks_rdy;
    assign strm.pt_ready = pt_rdy;
    assign strm.ct_data  = ct_data_q;
    assign strm.ct_valid = ct_valid_q;
    assign strm.ct_last  = ct_last_q;

    ks_full_blocks_push: assert property (@(posedge clk) disable iff (rst) fifo_full |-> !ks_rdy);

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Self-checking bench for rc4_xor_stream. Two instances share clock and reset:
// index 0 has DROP_N=0, index 1 has DROP_N=2; both use FIFO_DEPTH=4. Expected
// ciphertext entries {byte_cnt, last, data} are queued as plaintext is driven and
// compared on every ciphertext handshake.
module tb_rc4_xor_stream;
    import rc4_pkg::*;

    localparam int Limit = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start, busy, done;
    logic [1:0] ks_valid, pt_valid, pt_last, ct_ready;
    logic [1:0] ks_ready, pt_ready, ct_valid, ct_last;
    logic [7:0] ks_data [2];
    logic [7:0] pt_data [2];
    logic [7:0] ct_data [2];
    logic [15:0] byte_cnt [2];

    logic [7:0] ks_buf [2][64];
    logic [7:0] pt_buf [2][64];
    logic [24:0] exp0 [$];
    logic [24:0] exp1 [$];

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt [2];
    int run_len, max_run;

    rc4_xor_stream_if if0 ();
    rc4_xor_stream_if if1 ();

    assign if0.ks_data  = ks_data[0];
    assign if0.ks_valid = ks_valid[0];
    assign if0.pt_data  = pt_data[0];
    assign if0.pt_valid = pt_valid[0];
    assign if0.pt_last  = pt_last[0];
    assign if0.ct_ready = ct_ready[0];
    assign ks_ready[0]  = if0.ks_ready;
    assign pt_ready[0]  = if0.pt_ready;
    assign ct_data[0]   = if0.ct_data;
    assign ct_valid[0]  = if0.ct_valid;
    assign ct_last[0]   = if0.ct_last;

    assign if1.ks_data  = ks_data[1];
    assign if1.ks_valid = ks_valid[1];
    assign if1.pt_data  = pt_data[1];
    assign if1.pt_valid = pt_valid[1];
    assign if1.pt_last  = pt_last[1];
    assign if1.ct_ready = ct_ready[1];
    assign ks_ready[1]  = if1.ks_ready;
    assign pt_ready[1]  = if1.pt_ready;
    assign ct_data[1]   = if1.ct_data;
    assign ct_valid[1]  = if1.ct_valid;
    assign ct_last[1]   = if1.ct_last;

    rc4_xor_stream #(
        .DROP_N     (0),
        .FIFO_DEPTH (4)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start[0]),
        .busy     (busy[0]),
        .strm     (if0.slave),
        .byte_cnt (byte_cnt[0]),
        .done     (done[0])
    );

    rc4_xor_stream #(
        .DROP_N     (2),
        .FIFO_DEPTH (4)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start[1]),
        .busy     (busy[1]),
        .strm     (if1.slave),
        .byte_cnt (byte_cnt[1]),
        .done     (done[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ciphertext monitor / scoreboard.
    always @(negedge clk) begin
        logic [24:0] e;
        logic        got;
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                if (ct_valid[s] && ct_ready[s]) begin
                    got = 1'b0;
                    e   = '0;
                    if (s == 0 && exp0.size() > 0) begin
                        e = exp0.pop_front();
                        got = 1'b1;
                    end else if (s == 1 && exp1.size() > 0) begin
                        e = exp1.pop_front();
                        got = 1'b1;
                    end
                    if (!got) begin
                        check($sformatf("ct%0d_extra", s), 32'(ct_valid[s]), 32'd0);
                    end else begin
                        check($sformatf("ct%0d_data", s), 32'(ct_data[s]), 32'(e[7:0]));
                        check($sformatf("ct%0d_last", s), 32'(ct_last[s]), 32'(e[8]));
                        check($sformatf("ct%0d_cnt", s), 32'(byte_cnt[s]), 32'(e[24:9]));
                        check($sformatf("ct%0d_done", s), 32'(done[s]), 32'(e[8]));
                    end
                    hs_cnt[s]++;
                end else if (done[s]) begin
                    check($sformatf("done%0d_spurious", s), 32'(done[s]), 32'd0);
                end
            end
            if (ct_valid[0]) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
    endtask

    task automatic feed_ks(input int s, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            ks_valid[s] = 1'b1;
            ks_data[s]  = ks_buf[s][i];
            t = 0;
            @(negedge clk);
            while (!ks_ready[s] && t < Limit) begin
                @(negedge clk);
                t++;
            end
            if (!ks_ready[s]) check($sformatf("ks%0d_timeout", s), 32'(ks_ready[s]), 32'd1);
            @(posedge clk); #1;
        end
        ks_valid[s] = 1'b0;
    endtask

    task automatic feed_pt(input int s, input int n, input int drop);
        int t;
        logic [24:0] e;
        for (int i = 0; i < n; i++) begin
            pt_valid[s] = 1'b1;
            pt_data[s]  = pt_buf[s][i];
            pt_last[s]  = (i == n - 1);
            e = {16'(i + 1), (i == n - 1), pt_buf[s][i] ^ ks_buf[s][i + drop]};
            if (s == 0) exp0.push_back(e);
            else        exp1.push_back(e);
            t = 0;
            @(negedge clk);
            while (!pt_ready[s] && t < Limit) begin
                @(negedge clk);
                t++;
            end
            if (!pt_ready[s]) check($sformatf("pt%0d_timeout", s), 32'(pt_ready[s]), 32'd1);
            @(posedge clk); #1;
        end
        pt_valid[s] = 1'b0;
        pt_last[s]  = 1'b0;
    endtask

    // mode 1: hold ct_ready low for a while; mode 2: pulse start while busy.
    task automatic disturb(input int s, input int mode, input int after);
        int t;
        int base;
        logic [7:0] held;
        if (mode == 0) return;
        base = hs_cnt[s];
        t = 0;
        while (hs_cnt[s] < base + after && t < Limit) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (mode == 1) begin
            ct_ready[s] = 1'b0;
            @(negedge clk);
            held = ct_data[s];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("bp_ct_hold", 32'(ct_data[s]), 32'(held));
                check("bp_pt_ready", 32'(pt_ready[s]), 32'd0);
            end
            check("bp_ks_ready_full", 32'(ks_ready[s]), 32'd0);
            @(posedge clk); #1;
            ct_ready[s] = 1'b1;
        end else begin
            pulse_start(s);
        end
    endtask

    task automatic wait_done(input int s);
        int t;
        t = 0;
        @(negedge clk);
        while (!done[s] && t < Limit) begin
            @(negedge clk);
            t++;
        end
        if (!done[s]) check($sformatf("done%0d_timeout", s), 32'(done[s]), 32'd1);
        @(negedge clk);
        check($sformatf("busy%0d_after_done", s), 32'(busy[s]), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_msg(input int s, input int n, input int drop, input int mode,
                           input int after);
        pulse_start(s);
        fork
            feed_ks(s, n + drop);
            feed_pt(s, n, drop);
            disturb(s, mode, after);
        join
        wait_done(s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = '0;
        ks_valid = '0;
        pt_valid = '0;
        pt_last = '0;
        ct_ready = '1;
        for (int s = 0; s < 2; s++) begin
            ks_data[s] = '0;
            pt_data[s] = '0;
            hs_cnt[s] = 0;
        end
        run_len = 0;
        max_run = 0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_ks_ready", 32'(ks_ready[s]), 32'd0);
            check("rst_ct_valid", 32'(ct_valid[s]), 32'd0);
            check("rst_ct_data", 32'(ct_data[s]), 32'd0);
            check("rst_byte_cnt", 32'(byte_cnt[s]), 32'd0);
            check("rst_done", 32'(done[s]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic three-byte message, no drop: 01^10, 02^20, 03^30.
        ks_buf[0][0] = 8'h01; ks_buf[0][1] = 8'h02; ks_buf[0][2] = 8'h03;
        pt_buf[0][0] = 8'h10; pt_buf[0][1] = 8'h20; pt_buf[0][2] = 8'h30;
        run_msg(0, 3, 0, 0, 0);
        check("basic_byte_cnt", 32'(byte_cnt[0]), 32'd3);

        // Drop of two keystream bytes: 5C ^ 5C = 00.
        ks_buf[1][0] = 8'hAA; ks_buf[1][1] = 8'hBB; ks_buf[1][2] = 8'h5C;
        pt_buf[1][0] = 8'h5C;
        run_msg(1, 1, 2, 0, 0);
        check("drop_byte_cnt", 32'(byte_cnt[1]), 32'd1);

        // Backpressure mid-stream.
        for (int i = 0; i < 10; i++) begin
            ks_buf[0][i] = 8'(i * 8'h11 + 8'h07);
            pt_buf[0][i] = 8'($urandom_range(0, 255));
        end
        run_msg(0, 10, 0, 1, 2);

        // Full-rate streaming.
        for (int i = 0; i < 16; i++) begin
            ks_buf[0][i] = 8'($urandom_range(0, 255));
            pt_buf[0][i] = 8'($urandom_range(0, 255));
        end
        run_len = 0;
        max_run = 0;
        run_msg(0, 16, 0, 0, 0);
        check("tput_ct_valid_run", 32'(max_run), 32'd16);

        // Reset in RUN with two bytes buffered.
        pulse_start(0);
        ks_valid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ks_data[0] = 8'hE0 + 8'(i);
            @(negedge clk);
            check("rst_ks_accept", 32'(ks_ready[0]), 32'd1);
            @(posedge clk); #1;
        end
        ks_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_ks_ready", 32'(ks_ready[0]), 32'd0);
        check("mid_rst_pt_ready", 32'(pt_ready[0]), 32'd0);
        check("mid_rst_ct_valid", 32'(ct_valid[0]), 32'd0);
        check("mid_rst_ct_last", 32'(ct_last[0]), 32'd0);
        check("mid_rst_ct_data", 32'(ct_data[0]), 32'd0);
        check("mid_rst_byte_cnt", 32'(byte_cnt[0]), 32'd0);
        check("mid_rst_done", 32'(done[0]), 32'd0);
        @(posedge clk); #1;

        // Fresh message after reset uses only new keystream.
        for (int i = 0; i < 4; i++) begin
            ks_buf[0][i] = 8'h30 + 8'(i);
            pt_buf[0][i] = 8'hC0 + 8'(i * 3);
        end
        run_msg(0, 4, 0, 0, 0);

        // pt_valid in IDLE is not consumed.
        pt_valid[0] = 1'b1;
        pt_data[0]  = 8'h77;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_pt_ready", 32'(pt_ready[0]), 32'd0);
            check("idle_busy", 32'(busy[0]), 32'd0);
        end
        @(posedge clk); #1;
        pt_valid[0] = 1'b0;

        // start while busy is ignored; byte_cnt keeps counting.
        for (int i = 0; i < 5; i++) begin
            ks_buf[0][i] = 8'h5A ^ 8'(i);
            pt_buf[0][i] = 8'h90 + 8'(i);
        end
        run_msg(0, 5, 0, 2, 1);
        check("restart_byte_cnt", 32'(byte_cnt[0]), 32'd5);

        check("exp0_left", 32'(exp0.size()), 32'd0);
        check("exp1_left", 32'(exp1.size()), 32'd0);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
